roulette_spin_animator: RTL and testbench
=========================================

# roulette_spin_animator

Animates the roulette ball between the register file's result output and `led_decoder`. On a start pulse it samples the 6-bit winning pocket and drives a position index that spins at full speed for a minimum number of laps. It then decelerates over exactly one final lap and lands on the winning pocket. Its `pos` output replaces the register file's result as the index fed to `led_decoder`.

## Interface
- `NUM_POS`, default 38: pockets on the wheel; legal positions are 0..NUM_POS-1 (range 2..64).
- `FAST_DIV`, default 500000: clock cycles per step at full speed (≥1).
- `SLOW_STEP`, default 50000: cycles added to the step period on each deceleration step.
- `MIN_LAPS`, default 3: minimum full-speed laps before deceleration (≥1).

Ports:
- `clock` in 1: single clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low.
- `spin_start` in 1: one-cycle request to start a spin.
- `target` in 6: winning pocket from the register file's result output; sampled only when a start is accepted.
- `pos` out 6: current ball position, fed to `led_decoder`.
- `busy` out 1: high while a spin is in progress.
- `done` out 1: one-cycle pulse on the edge where the ball lands.
- `bad_target` out 1: one-cycle pulse when a start is rejected.

## Operation
- Reset value of every output while `reset`=0: `pos`=0, `busy`=0, `done`=0, `bad_target`=0. Internal state is IDLE and all counters are 0.
- States are IDLE, SPIN and DECEL.
- **IDLE**
  - `spin_start`=1 with `target`<NUM_POS:
    - latch `target` into `tgt`;
    - set step period `per`=FAST_DIV, divider `div`=0, step count `steps`=0;
    - go to SPIN.
  - `spin_start`=1 with `target`≥NUM_POS: pulse `bad_target`, stay in IDLE, leave `pos` unchanged.
- **Stepping (SPIN and DECEL)**
  - `div` counts 0..`per`-1.
  - On the edge where `div`=`per`-1:
    - `div`←0;
    - `pos`←`pos`+1, wrapping from NUM_POS-1 to 0;
    - `steps`←`steps`+1.
- **SPIN**
  - Exit test uses the post-step values on each step.
  - If `steps`≥MIN_LAPS·NUM_POS and `pos`=`tgt`: go to DECEL on that same edge, with `per`←FAST_DIV+SLOW_STEP and a lap counter `k`←0.
- **DECEL**
  - Each step increments `k` and increases `per` by SLOW_STEP.
  - The step period of the j-th deceleration step (j=1..NUM_POS) is FAST_DIV+j·SLOW_STEP.
  - On the step where `k` reaches NUM_POS, `pos`=`tgt` by construction. On that edge:
    - `done`←1 for one cycle;
    - `busy`←0;
    - go to IDLE.
- `busy`=1 in SPIN and DECEL.
- `spin_start` while busy is ignored. `target` changes while busy are ignored.
- A new spin starts from the current `pos` (the previous landing pocket), not from 0.
- Arithmetic widths:
  - `per` and `div` are 32-bit unsigned;
  - FAST_DIV+NUM_POS·SLOW_STEP < 2^32 is a parameter legality requirement;
  - `steps` is 16-bit and saturates, so it cannot wrap before the exit test.

## Timing
- Edge 0 is the edge that samples an accepted `spin_start`. `busy` is high after edge 0.
- First `pos` change occurs at edge FAST_DIV.
- Total spin length in cycles is S·FAST_DIV + NUM_POS·FAST_DIV + SLOW_STEP·NUM_POS·(NUM_POS+1)/2.
  - S is the SPIN step count: the smallest n ≥ MIN_LAPS·NUM_POS with (start+n) mod NUM_POS = `tgt`.
- `done` and the final `pos` update occur on the same edge; `busy` is low after it.
- A `spin_start` in the cycle `done`=1 is accepted (state is already IDLE).
- `bad_target` is asserted the cycle after the rejected request.
- Async reset mid-spin:
  - outputs reach their reset values immediately, without waiting for a clock edge;
  - no `done` pulse is produced;
  - after release, the block waits in IDLE for a new `spin_start`.

## Test plan
Params for all scenarios: NUM_POS=8, FAST_DIV=2, SLOW_STEP=1, MIN_LAPS=1.
- **Basic spin:** after reset, `spin_start` with `target`=3 at edge 0 → `pos` 1 at edge 2, 11 SPIN steps (22 cycles), DECEL periods 3..10 (52 cycles), `done` and `pos`=3 at edge 74, `busy` low after.
- **Target equals start:** from `pos`=0, `target`=0 → 8 SPIN steps, `done` at edge 68 with `pos`=0.
- **Illegal target:** `target`=9 → `bad_target` pulses one cycle, `busy`=0, `pos` unchanged.
- **Start ignored while busy:** `spin_start` with `target`=5 at edge 10 of a spin to 3 → no effect; lands on 3 at edge 74.
- **Reset mid-DECEL:** assert `reset`=0 at edge 50 → `pos`=0 and `busy`=0 immediately, no `done`; after release, a new spin to 2 from 0 gives `done` at edge 72 (10 SPIN steps).
- **Back-to-back:** `spin_start` with `target`=6 in the `done` cycle of the basic spin → accepted; the spin starts from 3, SPIN runs 11 steps, and `done` arrives 74 cycles later with `pos`=6.

Source files
------------

// File: rtl/roulette_spin_animator.sv
// rtl/roulette_spin_animator.sv - roulette ball position animator with full-speed laps and a one-lap deceleration
//
// Ports:
//   clock       in   rising-edge clock
//   reset       in   asynchronous active-low reset
//   spin_start  in   one-cycle spin request (ignored while busy)
//   target [6]  in   winning pocket, sampled when a start is accepted
//   pos    [6]  out  current ball position, feeds led_decoder
//   busy        out  high while spinning or decelerating
//   done        out  one-cycle pulse on the landing edge
//   bad_target  out  one-cycle pulse when a start is rejected (target >= NUM_POS)

module roulette_spin_animator #(
    parameter int unsigned NUM_POS   = 38,
    parameter int unsigned FAST_DIV  = 500000,
    parameter int unsigned SLOW_STEP = 50000,
    parameter int unsigned MIN_LAPS  = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       spin_start,
    input  logic [5:0] target,
    output logic [5:0] pos,
    output logic       busy,
    output logic       done,
    output logic       bad_target
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPIN  = 2'd1,
        DECEL = 2'd2
    } state_t;

    localparam logic [5:0]  LAST_POS  = 6'(NUM_POS - 1);
    localparam logic [6:0]  NUM_POS_W = 7'(NUM_POS);
    localparam int unsigned LAP_STEPS = MIN_LAPS * NUM_POS;
    localparam logic [31:0] FAST_W    = 32'(FAST_DIV);
    localparam logic [31:0] SLOW_W    = 32'(SLOW_STEP);

    state_t      state, state_n;
    logic [5:0]  pos_n;
    logic [5:0]  tgt, tgt_n;
    logic [31:0] per, per_n;
    logic [31:0] div, div_n;
    logic [15:0] steps, steps_n;
    logic [6:0]  k, k_n;
    logic        done_n;
    logic        bad_n;

    // Helper values for the stepping datapath.
    logic        step_edge;
    logic [5:0]  pos_inc;
    logic [15:0] steps_inc;
    logic [6:0]  k_inc;
    logic        target_ok;

    always_comb begin
        step_edge = (div == per - 32'd1);
        pos_inc   = (pos == LAST_POS) ? 6'd0 : pos + 6'd1;
        // Saturate so a very long SPIN can never wrap below the lap threshold.
        steps_inc = (steps == 16'hFFFF) ? steps : steps + 16'd1;
        k_inc     = k + 7'd1;
        target_ok = ({1'b0, target} < NUM_POS_W);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pos        <= 6'd0;
            tgt        <= 6'd0;
            per        <= 32'd0;
            div        <= 32'd0;
            steps      <= 16'd0;
            k          <= 7'd0;
            done       <= 1'b0;
            bad_target <= 1'b0;
        end else begin
            state      <= state_n;
            pos        <= pos_n;
            tgt        <= tgt_n;
            per        <= per_n;
            div        <= div_n;
            steps      <= steps_n;
            k          <= k_n;
            done       <= done_n;
            bad_target <= bad_n;
        end
    end

    always_comb begin
        state_n = state;
        pos_n   = pos;
        tgt_n   = tgt;
        per_n   = per;
        div_n   = div;
        steps_n = steps;
        k_n     = k;
        done_n  = 1'b0;
        bad_n   = 1'b0;

        case (state)
            IDLE: begin
                if (spin_start) begin
                    if (target_ok) begin
                        // pos is kept: the new spin starts from the last landing pocket.
                        tgt_n   = target;
                        per_n   = FAST_W;
                        div_n   = 32'd0;
                        steps_n = 16'd0;
                        k_n     = 7'd0;
                        state_n = SPIN;
                    end else begin
                        bad_n = 1'b1;
                    end
                end
            end

            SPIN: begin
                if (step_edge) begin
                    div_n   = 32'd0;
                    pos_n   = pos_inc;
                    steps_n = steps_inc;
                    // Exit decision uses the values produced by this very step.
                    if ((32'(steps_inc) >= LAP_STEPS) && (pos_inc == tgt)) begin
                        state_n = DECEL;
                        per_n   = FAST_W + SLOW_W;
                        k_n     = 7'd0;
                    end
                end else begin
                    div_n = div + 32'd1;
                end
            end

            DECEL: begin
                if (step_edge) begin
                    div_n = 32'd0;
                    pos_n = pos_inc;
                    steps_n = steps_inc;
                    k_n   = k_inc;
                    per_n = per + SLOW_W;
                    // After exactly one lap from tgt the ball is back on tgt.
                    if (k_inc == NUM_POS_W) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    div_n = div + 32'd1;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_roulette_spin_animator.sv
// tb/tb_roulette_spin_animator.sv - directed self-checking bench for roulette_spin_animator

module tb_roulette_spin_animator;

    logic       clock;
    logic       reset;
    logic       spin_start;
    logic [5:0] target;
    logic [5:0] pos;
    logic       busy;
    logic       done;
    logic       bad_target;

    int vectors;
    int miscompares;

    roulette_spin_animator #(
        .NUM_POS   (8),
        .FAST_DIV  (2),
        .SLOW_STEP (1),
        .MIN_LAPS  (1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .spin_start (spin_start),
        .target     (target),
        .pos        (pos),
        .busy       (busy),
        .done       (done),
        .bad_target (bad_target)
    );

    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n edges, counting done pulses seen along the way.
    task automatic advance(input int n, output int dones);
        dones = 0;
        repeat (n) begin
            tick;
            if (done === 1'b1) dones++;
        end
    endtask

    // Accept a spin at edge 0 and expect the landing exactly at edge total.
    task automatic spin_check(input string tag, input logic [5:0] t, input int total,
                              input logic [5:0] exp_pos);
        int d;
        target     = t;
        spin_start = 1'b1;
        tick;
        spin_start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        advance(total - 1, d);
        check({tag, "_early_done"}, d, 32'd0);
        advance(1, d);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_pos"}, 32'(pos), 32'(exp_pos));
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int d;
        vectors     = 0;
        miscompares = 0;
        clock       = 1'b0;
        reset       = 1'b0;
        spin_start  = 1'b0;
        target      = 6'd0;

        repeat (2) tick;
        check("rst_pos", 32'(pos), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bad", 32'(bad_target), 32'd0);
        reset = 1'b1;
        tick;

        // Basic spin to 3 from 0, with an ignored start (target 5) at edge 10.
        target     = 6'd3;
        spin_start = 1'b1;
        tick;                                   // edge 0
        spin_start = 1'b0;
        target     = 6'd7;
        check("basic_busy0", 32'(busy), 32'd1);
        check("basic_pos0", 32'(pos), 32'd0);
        advance(1, d);                          // edge 1
        check("basic_pos1", 32'(pos), 32'd0);
        advance(1, d);                          // edge 2
        check("basic_pos2", 32'(pos), 32'd1);
        advance(7, d);                          // edge 9
        target     = 6'd5;
        spin_start = 1'b1;
        tick;                                   // edge 10
        spin_start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        check("ign_pos10", 32'(pos), 32'd5);
        advance(12, d);                         // edge 22: SPIN exits on pos 3
        check("basic_pos22", 32'(pos), 32'd3);
        advance(2, d);                          // edge 24
        check("decel_pos24", 32'(pos), 32'd3);
        advance(1, d);                          // edge 25: first DECEL step, period 3
        check("decel_pos25", 32'(pos), 32'd4);
        advance(48, d);                         // edge 73
        check("basic_no_early_done", d, 32'd0);
        check("basic_pos73", 32'(pos), 32'd2);
        advance(1, d);                          // edge 74
        check("basic_done", 32'(done), 32'd1);
        check("basic_pos74", 32'(pos), 32'd3);
        check("basic_busy_low", 32'(busy), 32'd0);

        // Back-to-back: request during the done cycle, 3 -> 6 lands 74 cycles later.
        spin_check("b2b", 6'd6, 74, 6'd6);
        tick;
        check("b2b_done_1cyc", 32'(done), 32'd0);

        // Illegal targets: 9 and the boundary value 8.
        target     = 6'd9;
        spin_start = 1'b1;
        tick;
        spin_start = 1'b0;
        check("bad9_pulse", 32'(bad_target), 32'd1);
        check("bad9_busy", 32'(busy), 32'd0);
        check("bad9_pos", 32'(pos), 32'd6);
        tick;
        check("bad9_1cyc", 32'(bad_target), 32'd0);
        target     = 6'd8;
        spin_start = 1'b1;
        tick;
        spin_start = 1'b0;
        check("bad8_pulse", 32'(bad_target), 32'd1);
        check("bad8_busy", 32'(busy), 32'd0);
        tick;
        check("bad8_1cyc", 32'(bad_target), 32'd0);
        check("bad8_pos", 32'(pos), 32'd6);

        // Highest legal target 7 from 6: 9 SPIN steps -> 18 + 52 = 70.
        spin_check("max_tgt", 6'd7, 70, 6'd7);
        tick;

        // Reset in DECEL: spin 7 -> 0 (DECEL from edge 18), reset after edge 50.
        target     = 6'd0;
        spin_start = 1'b1;
        tick;
        spin_start = 1'b0;
        advance(50, d);
        check("rmid_no_done", d, 32'd0);
        check("rmid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b0;
        #2;
        check("rmid_pos_async", 32'(pos), 32'd0);
        check("rmid_busy_async", 32'(busy), 32'd0);
        check("rmid_done_async", 32'(done), 32'd0);
        repeat (2) tick;
        reset = 1'b1;
        advance(6, d);
        check("rmid_no_done_after", d, 32'd0);
        check("rmid_idle", 32'(busy), 32'd0);
        check("rmid_pos_idle", 32'(pos), 32'd0);

        // Target equals start: 0 -> 0 takes 8 SPIN steps, lands at 68.
        spin_check("same", 6'd0, 68, 6'd0);
        tick;

        // 0 -> 2: 10 SPIN steps, lands at 72.
        spin_check("after_rst", 6'd2, 72, 6'd2);
        tick;
        check("final_done_low", 32'(done), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
